// File: rtl/turn_seq_param_pkg.sv
// Shared mode encodings and width helper for the turn-signal sequencer.
package turn_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_HAZ   = 2'b11
  } mode_e;

  // Counter width needed to hold values 0..n-1, never below one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turn_seq_param_if.sv
// Command/lamp bundle between the driver-control decode and the lamp drivers.
interface turn_seq_param_if
  import turn_seq_pkg::*;
#(
  parameter int LAMPS = 3
);
  logic [1:0]         D;
  logic               BRK;
  logic [2*LAMPS-1:0] Out;
  logic               Stb;
  mode_e              dbg_mode;

  // D/BRK are levels sampled every CLK edge; there is no backpressure.
  // Out and Stb are registered and valid every cycle after reset.
  modport master (output D, BRK, input Out, Stb, dbg_mode);
  modport slave  (input D, BRK, output Out, Stb, dbg_mode);
endinterface

// File: rtl/turn_seq_param_step_prescaler.sv
// Free-running step prescaler: step is high while the count sits at DIV-1.
module step_prescaler
  import turn_seq_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic step
);
  localparam int CW = width_of(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] c_q, c_d;

  assign step = (c_q == LAST);

  always_comb begin
    c_d = c_q + CW'(1);
    if (clr || step) c_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) c_q <= '0;
    else     c_q <= c_d;
  end
endmodule

// File: rtl/turn_seq_param.sv
// Turn/hazard/brake lamp sequencer for one light cluster with a programmable step rate.
module turn_seq_param
  import turn_seq_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV   = 1
) (
  input  logic CLK,
  input  logic RST,
  turn_seq_param_if.slave bus
);
  localparam int PW = width_of(LAMPS + 1);

  mode_e              m_q, m_d;
  logic [PW-1:0]      p_q, p_d;
  logic [2*LAMPS-1:0] out_q, out_d;
  logic               stb_q, stb_d;
  logic               chg, step;
  logic [LAMPS-1:0]   left_lit, right_lit, side_fill;

  assign chg = (bus.D != m_q);

  step_prescaler #(.DIV(DIV)) u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (chg),
    .step (step)
  );

  always_comb begin
    m_d   = m_q;
    p_d   = p_q;
    stb_d = 1'b0;
    if (chg) begin
      m_d = mode_e'(bus.D);
      p_d = (bus.D == MODE_OFF) ? PW'(0) : PW'(1);
    end else if (step) begin
      stb_d = 1'b1;
      case (m_q)
        MODE_RIGHT, MODE_LEFT: p_d = (p_q == PW'(LAMPS)) ? PW'(0) : p_q + PW'(1);
        MODE_HAZ:              p_d = (p_q == PW'(0)) ? PW'(1) : PW'(0);
        default:               p_d = PW'(0);
      endcase
    end

    // Lamp i counts outward from the centre of the cluster.
    left_lit  = '0;
    right_lit = '0;
    for (int i = 0; i < LAMPS; i++) begin
      left_lit[i]            = (i < int'(p_d));
      right_lit[LAMPS-1-i]   = (i < int'(p_d));
    end
    side_fill = bus.BRK ? '1 : '0;

    case (m_d)
      MODE_RIGHT: out_d = {side_fill, right_lit};
      MODE_LEFT:  out_d = {left_lit, side_fill};
      MODE_HAZ:   out_d = (p_d != PW'(0)) ? '1 : '0;
      default:    out_d = {side_fill, side_fill};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_q   <= MODE_OFF;
      p_q   <= '0;
      out_q <= '0;
      stb_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      p_q   <= p_d;
      out_q <= out_d;
      stb_q <= stb_d;
    end
  end

  assign bus.Out      = out_q;
  assign bus.Stb      = stb_q;
  assign bus.dbg_mode = m_q;
endmodule

// File: tb/tb_turn_seq_param.sv
// Bench for turn_seq_param: DIV=1 and DIV=4 instances share stimulus and are checked against a behavioural model.
module tb_turn_seq_param;
  import turn_seq_pkg::*;

  localparam int L = 3;

  logic       clk;
  logic       rst_drv;
  logic [1:0] d_drv;
  logic       brk_drv;

  int vectors;
  int miscompares;
  bit model_valid;

  turn_seq_param_if #(.LAMPS(L)) if0 ();
  turn_seq_param_if #(.LAMPS(L)) if1 ();

  assign if0.D   = d_drv;
  assign if0.BRK = brk_drv;
  assign if1.D   = d_drv;
  assign if1.BRK = brk_drv;

  turn_seq_param #(.LAMPS(L), .DIV(1)) dut0 (.CLK(clk), .RST(rst_drv), .bus(if0));
  turn_seq_param #(.LAMPS(L), .DIV(4)) dut1 (.CLK(clk), .RST(rst_drv), .bus(if1));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: one slot per instance
  int         mdiv [2] = '{1, 4};
  int         mm [2];
  int         mp [2];
  int         mc [2];
  logic [5:0] mout [2];
  logic       mstb [2];

  function automatic logic [5:0] lamps_for(input int m, input int p, input logic brk);
    int full, llit, rlit, side;
    full = (1 << L) - 1;
    llit = (1 << p) - 1;
    rlit = llit << (L - p);
    side = brk ? full : 0;
    case (m)
      1:       return 6'((side << L) | rlit);
      2:       return 6'((llit << L) | side);
      3:       return (p != 0) ? 6'h3f : 6'h00;
      default: return 6'((side << L) | side);
    endcase
  endfunction

  task automatic model_edge(input int k);
    if (rst_drv) begin
      mm[k] = 0; mp[k] = 0; mc[k] = 0; mstb[k] = 1'b0; mout[k] = '0;
      return;
    end
    if (int'(d_drv) != mm[k]) begin
      mm[k] = int'(d_drv);
      mp[k] = (d_drv != 2'b00) ? 1 : 0;
      mc[k] = 0;
      mstb[k] = 1'b0;
    end else if (mc[k] == mdiv[k] - 1) begin
      mc[k] = 0;
      mstb[k] = 1'b1;
      if (mm[k] == 1 || mm[k] == 2) mp[k] = (mp[k] + 1) % (L + 1);
      else if (mm[k] == 3)          mp[k] = 1 - mp[k];
      else                          mp[k] = 0;
    end else begin
      mc[k] = mc[k] + 1;
      mstb[k] = 1'b0;
    end
    mout[k] = lamps_for(mm[k], mp[k], brk_drv);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: compare both instances every cycle once reset has been seen
  always begin
    @(posedge clk);
    if (rst_drv) model_valid = 1'b1;
    if (model_valid) begin
      model_edge(0);
      model_edge(1);
      #2;
      chk("model_out_div1", 32'(if0.Out), 32'(mout[0]));
      chk("model_stb_div1", 32'(if0.Stb), 32'(mstb[0]));
      chk("model_out_div4", 32'(if1.Out), 32'(mout[1]));
      chk("model_stb_div4", 32'(if1.Stb), 32'(mstb[1]));
    end
  end

  // driver tasks
  task automatic tick(input logic [1:0] d, input logic b, input logic r);
    d_drv = d; brk_drv = b; rst_drv = r;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp_q[$];

  task automatic run_expect(input string nm, input logic [1:0] d, input logic b);
    while (exp_q.size() > 0) begin
      tick(d, b, 1'b0);
      chk(nm, 32'(if0.Out), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; model_valid = 1'b0;
    d_drv = 2'b01; brk_drv = 1'b1; rst_drv = 1'b1;

    // reset ignores D and BRK
    tick(2'b01, 1'b1, 1'b1);
    tick(2'b01, 1'b1, 1'b1);
    chk("reset_out", 32'(if0.Out), 32'h00);
    chk("reset_stb", 32'(if0.Stb), 32'h0);

    exp_q = '{6'b000100, 6'b000110, 6'b000111, 6'b000000, 6'b000100};
    run_expect("right_seq", 2'b01, 1'b0);

    tick(2'b00, 1'b0, 1'b1);
    exp_q = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000};
    run_expect("left_seq", 2'b10, 1'b0);
    chk("dbg_mode_left", 32'(if0.dbg_mode), 32'(MODE_LEFT));

    tick(2'b00, 1'b0, 1'b1);
    exp_q = '{6'b111111, 6'b000000, 6'b111111};
    run_expect("hazard_seq", 2'b11, 1'b0);

    tick(2'b00, 1'b0, 1'b1);
    exp_q = '{6'b111100, 6'b111110, 6'b111111, 6'b111000};
    run_expect("right_brake", 2'b01, 1'b1);
    exp_q = '{6'b111111};
    run_expect("off_brake", 2'b00, 1'b1);
    exp_q = '{6'b111111, 6'b000000, 6'b111111};
    run_expect("hazard_brake", 2'b11, 1'b1);

    // BRK toggling mid-sequence leaves the phase untouched
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b01, 1'b0, 1'b0); chk("brk_p1", 32'(if0.Out), 32'h04);
    tick(2'b01, 1'b1, 1'b0); chk("brk_p2", 32'(if0.Out), 32'h3e);
    tick(2'b01, 1'b0, 1'b0); chk("brk_p3", 32'(if0.Out), 32'h07);

    // DIV=4 instance: each pattern held 4 edges, Stb on the step edge
    tick(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(2'b01, 1'b0, 1'b0);
      chk("div4_hold1", 32'(if1.Out), 32'h04);
      chk("div4_stb_lo", 32'(if1.Stb), 32'h0);
    end
    tick(2'b01, 1'b0, 1'b0);
    chk("div4_step2", 32'(if1.Out), 32'h06);
    chk("div4_stb_hi", 32'(if1.Stb), 32'h1);
    tick(2'b01, 1'b0, 1'b0);
    chk("div4_step2_hold", 32'(if1.Out), 32'h06);
    chk("div4_stb_pulse", 32'(if1.Stb), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(2'b10, 1'b0, 1'b0);
      chk("div4_switch_left", 32'(if1.Out), 32'h08);
    end
    chk("div4_dbg_mode", 32'(if1.dbg_mode), 32'(MODE_LEFT));
    tick(2'b10, 1'b0, 1'b0);
    chk("div4_left_step", 32'(if1.Out), 32'h18);
    chk("div4_left_stb", 32'(if1.Stb), 32'h1);

    // reset mid-sequence
    tick(2'b00, 1'b0, 1'b1);
    tick(2'b10, 1'b0, 1'b0); chk("mid_rst_a", 32'(if0.Out), 32'h08);
    tick(2'b10, 1'b0, 1'b0); chk("mid_rst_b", 32'(if0.Out), 32'h18);
    tick(2'b10, 1'b0, 1'b1); chk("mid_rst_clear", 32'(if0.Out), 32'h00);
    tick(2'b10, 1'b0, 1'b0); chk("mid_rst_restart", 32'(if0.Out), 32'h08);

    // a few mixed cycles for the scoreboard
    for (int i = 0; i < 40; i++) begin
      tick(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) tick(d_drv, brk_drv, 1'b0);
    end

    tick(2'b00, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
